// File: rtl/kamus_pkg.sv
// kamus_pkg: shared CSR definitions for the kamus core.
//   csr_e     - 12-bit CSR address map
//   csr_op_e  - write-back CSR operation (write / set / clear)
//   MCAUSE_*  - synchronous exception codes
//   *_BIT     - mstatus / mip / mie field positions
//   csr_apply_op - read-modify-write combine of old value and source
package kamus_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MBADADDR  = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_DSCRATCH  = 12'h7B2,
        CSR_MTIMECMP  = 12'h7C0,
        CSR_MTIMECMPH = 12'h7C1,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_TIME      = 12'hC01,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_TIMEH     = 12'hC81,
        CSR_INSTRETH  = 12'hC82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_e;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_W    = 2'b01,
        CSR_S    = 2'b10,
        CSR_C    = 2'b11
    } csr_op_e;

    localparam logic [3:0] MCAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] MCAUSE_INSTR_FAULT    = 4'd1;
    localparam logic [3:0] MCAUSE_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] MCAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] MCAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] MCAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] MCAUSE_STORE_FAULT    = 4'd7;
    localparam logic [3:0] MCAUSE_ECALL_M        = 4'd11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // mip and mie share the same field positions
    localparam int MIP_MSIP_BIT = 3;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] src);
        logic [31:0] res;
        case (op)
            CSR_W:   res = src;
            CSR_S:   res = old_val | src;
            CSR_C:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/kamus_csr_counter64.sv
// kamus_csr_counter64: 64-bit free-running counter with separately
// writable low and high halves.
//   clk_i, rst_i           - clock, synchronous active-high reset (clears to 0)
//   inc_i                  - add one this cycle
//   lo_we_i / lo_wdata_i   - replace bits [31:0]
//   hi_we_i / hi_wdata_i   - replace bits [63:32]
//   count_o                - current count
// A write to either half suppresses that cycle's increment; the unwritten
// half holds its value.
module kamus_csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        lo_we_i,
    input  logic [31:0] lo_wdata_i,
    input  logic        hi_we_i,
    input  logic [31:0] hi_wdata_i,
    output logic [63:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (lo_we_i || hi_we_i) begin
            if (lo_we_i) count_o[31:0]  <= lo_wdata_i;
            if (hi_we_i) count_o[63:32] <= hi_wdata_i;
        end else if (inc_i) begin
            count_o <= count_o + 64'd1;
        end
    end

endmodule

// File: rtl/kamus_csr_file.sv
// kamus_csr_file: architectural CSR storage, counters, trap/MRET state and
// interrupt-pending generation.
//   csr_rd_addr_i/csr_rd_data_o/csr_illegal_o - combinational EX-stage read
//   csr_wr_en_i/op/addr/src                   - WB-stage read-modify-write commit
//   instr_retire_i                            - instret increment
//   trap_i/trap_cause_i/trap_pc_i/trap_val_i  - synchronous exception entry
//   mret_i                                    - MRET retire
//   meip_i/msip_i                             - level interrupt lines
//   trap_vector_o/mepc_o/irq_pending_o        - redirect information
// Build option KAMUS_MACHINE_MODE_EN: when defined, all machine-mode CSRs,
// trap/MRET handling and interrupts exist; otherwise only the user counter
// CSRs are implemented and the trap/interrupt inputs are ignored.
module kamus_csr_file
    import kamus_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] csr_rd_addr_i,
    output logic [31:0] csr_rd_data_o,
    output logic        csr_illegal_o,
    input  logic        csr_wr_en_i,
    input  logic [1:0]  csr_wr_op_i,
    input  logic [11:0] csr_wr_addr_i,
    input  logic [31:0] csr_wr_src_i,
    input  logic        instr_retire_i,
    input  logic        trap_i,
    input  logic [3:0]  trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_val_i,
    input  logic        mret_i,
    input  logic        meip_i,
    input  logic        msip_i,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending_o
);

    logic [63:0] cycles;
    logic [63:0] instret;
    logic        cyc_lo_we, cyc_hi_we, ins_lo_we, ins_hi_we;
    logic [31:0] cnt_wdata;
    logic [32:0] rd_result;

`ifdef KAMUS_MACHINE_MODE_EN
    logic [63:0] timecmp;
    logic [31:0] mtvec, mscratch, mepc, mbadaddr, dscratch;
    logic        mstatus_mie, mstatus_mpie;
    logic        mcause_int;
    logic [3:0]  mcause_code;
    logic [2:0]  mie_en;    // {meie, mtie, msie}
    logic [2:0]  mip_vec;   // {meip, mtip, msip}
    logic [31:0] mstatus_rd, mie_rd, mip_rd;
    logic        wr_valid;
    logic [32:0] wr_rmw;
    logic [31:0] wr_new;
`endif

    // Returns {illegal, data} for a CSR address from current register state.
    function automatic logic [32:0] csr_read(input logic [11:0] addr);
        logic [32:0] r;
        r = '0;
        case (addr)
            CSR_CYCLE, CSR_TIME:     r[31:0] = cycles[31:0];
            CSR_CYCLEH, CSR_TIMEH:   r[31:0] = cycles[63:32];
            CSR_INSTRET:             r[31:0] = instret[31:0];
            CSR_INSTRETH:            r[31:0] = instret[63:32];
`ifdef KAMUS_MACHINE_MODE_EN
            CSR_MCYCLE:              r[31:0] = cycles[31:0];
            CSR_MCYCLEH:             r[31:0] = cycles[63:32];
            CSR_MINSTRET:            r[31:0] = instret[31:0];
            CSR_MINSTRETH:           r[31:0] = instret[63:32];
            CSR_MSTATUS:             r[31:0] = mstatus_rd;
            CSR_MISA:                r[31:0] = MISA_VALUE;
            CSR_MIE:                 r[31:0] = mie_rd;
            CSR_MIP:                 r[31:0] = mip_rd;
            CSR_MTVEC:               r[31:0] = mtvec;
            CSR_MSCRATCH:            r[31:0] = mscratch;
            CSR_MEPC:                r[31:0] = mepc;
            CSR_MCAUSE:              r[31:0] = {mcause_int, 27'b0, mcause_code};
            CSR_MBADADDR:            r[31:0] = mbadaddr;
            CSR_DSCRATCH:            r[31:0] = dscratch;
            CSR_MTIMECMP:            r[31:0] = timecmp[31:0];
            CSR_MTIMECMPH:           r[31:0] = timecmp[63:32];
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MHARTID: r[31:0] = '0;
`endif
            default:                 r = {1'b1, 32'h0};
        endcase
        return r;
    endfunction

    always_comb begin
        rd_result = csr_read(csr_rd_addr_i);
    end

    assign csr_rd_data_o = rd_result[31:0];
    assign csr_illegal_o = rd_result[32];

`ifdef KAMUS_MACHINE_MODE_EN
    assign mip_vec = {meip_i, (cycles >= timecmp), msip_i};

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie;
        mie_rd = '0;
        mie_rd[MIP_MEIP_BIT] = mie_en[2];
        mie_rd[MIP_MTIP_BIT] = mie_en[1];
        mie_rd[MIP_MSIP_BIT] = mie_en[0];
        mip_rd = '0;
        mip_rd[MIP_MEIP_BIT] = mip_vec[2];
        mip_rd[MIP_MTIP_BIT] = mip_vec[1];
        mip_rd[MIP_MSIP_BIT] = mip_vec[0];
    end

    assign wr_valid = csr_wr_en_i && (csr_wr_op_i != CSR_NONE);

    always_comb begin
        wr_rmw = csr_read(csr_wr_addr_i);
        wr_new = csr_apply_op(csr_op_e'(csr_wr_op_i), wr_rmw[31:0], csr_wr_src_i);
    end

    assign cnt_wdata = wr_new;
    assign cyc_lo_we = wr_valid && (csr_wr_addr_i == CSR_MCYCLE);
    assign cyc_hi_we = wr_valid && (csr_wr_addr_i == CSR_MCYCLEH);
    assign ins_lo_we = wr_valid && (csr_wr_addr_i == CSR_MINSTRET);
    assign ins_hi_we = wr_valid && (csr_wr_addr_i == CSR_MINSTRETH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timecmp      <= '1;
            mtvec        <= RESET_MTVEC;
            mscratch     <= '0;
            mepc         <= '0;
            mbadaddr     <= '0;
            dscratch     <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mcause_int   <= 1'b0;
            mcause_code  <= '0;
            mie_en       <= '0;
        end else begin
            // Registers touched by trap/MRET only accept a CSR write when no
            // higher-priority event targets them in the same cycle.
            if (wr_valid) begin
                case (csr_wr_addr_i)
                    CSR_MTVEC:     mtvec          <= wr_new;
                    CSR_MSCRATCH:  mscratch       <= wr_new;
                    CSR_DSCRATCH:  dscratch       <= wr_new;
                    CSR_MTIMECMP:  timecmp[31:0]  <= wr_new;
                    CSR_MTIMECMPH: timecmp[63:32] <= wr_new;
                    CSR_MIE:       mie_en <= {wr_new[MIP_MEIP_BIT], wr_new[MIP_MTIP_BIT],
                                              wr_new[MIP_MSIP_BIT]};
                    CSR_MEPC:      if (!trap_i) mepc <= wr_new;
                    CSR_MBADADDR:  if (!trap_i) mbadaddr <= wr_new;
                    CSR_MCAUSE: begin
                        if (!trap_i) begin
                            mcause_int  <= wr_new[31];
                            mcause_code <= wr_new[3:0];
                        end
                    end
                    CSR_MSTATUS: begin
                        if (!trap_i && !mret_i) begin
                            mstatus_mie  <= wr_new[MSTATUS_MIE_BIT];
                            mstatus_mpie <= wr_new[MSTATUS_MPIE_BIT];
                        end
                    end
                    default: ;
                endcase
            end
            if (trap_i) begin
                mepc         <= trap_pc_i;
                mcause_int   <= 1'b0;
                mcause_code  <= trap_cause_i;
                mbadaddr     <= trap_val_i;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_i) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    assign trap_vector_o = {mtvec[31:2], 2'b00};
    assign mepc_o        = {mepc[31:2], 2'b00};
    assign irq_pending_o = mstatus_mie & |(mip_vec & mie_en);
`else
    logic unused_mm;
    assign unused_mm = ^{csr_wr_en_i, csr_wr_op_i, csr_wr_addr_i, csr_wr_src_i,
                         trap_i, trap_cause_i, trap_pc_i, trap_val_i,
                         mret_i, meip_i, msip_i, MISA_VALUE};

    assign cnt_wdata     = '0;
    assign cyc_lo_we     = 1'b0;
    assign cyc_hi_we     = 1'b0;
    assign ins_lo_we     = 1'b0;
    assign ins_hi_we     = 1'b0;
    assign trap_vector_o = RESET_MTVEC;
    assign mepc_o        = '0;
    assign irq_pending_o = 1'b0;
`endif

    kamus_csr_counter64 u_cycles (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (1'b1),
        .lo_we_i    (cyc_lo_we),
        .lo_wdata_i (cnt_wdata),
        .hi_we_i    (cyc_hi_we),
        .hi_wdata_i (cnt_wdata),
        .count_o    (cycles)
    );

    kamus_csr_counter64 u_instret (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (instr_retire_i),
        .lo_we_i    (ins_lo_we),
        .lo_wdata_i (cnt_wdata),
        .hi_we_i    (ins_hi_we),
        .hi_wdata_i (cnt_wdata),
        .count_o    (instret)
    );

endmodule

// File: doc/kamus_csr_file.md
Name: kamus_csr_file

Overview:
- Architectural CSR storage and write side for the kamus core.
- EX-stage CSRRW/CSRRS/CSRRC reads are served combinationally from this block.
- Read-modify-write commits arrive from the write-back stage.
- Also owns the cycle/instret/timer counters, trap-entry and MRET state updates, and interrupt-pending generation toward the fetch/redirect logic.

Parameters:
RESET_MTVEC, 32'h0000_0100, mtvec reset value and fixed trap vector when machine mode is compiled out
MISA_VALUE, 32'h4000_0100, constant returned for MISA (RV32I)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
csr_rd_addr_i  in  12  CSR address from EX (instruction funct12)
csr_rd_data_o  out  32  current CSR value, combinational
csr_illegal_o  out  1  rd address unimplemented, combinational
csr_wr_en_i  in  1  commit a CSR write this cycle (WB stage)
csr_wr_op_i  in  2  csr_op_e: CSR_W, CSR_S, CSR_C
csr_wr_addr_i  in  12  CSR address being written
csr_wr_src_i  in  32  rs1 value or zero-extended zimm
instr_retire_i  in  1  one instruction retired this cycle
trap_i  in  1  take synchronous exception this cycle
trap_cause_i  in  4  exception code
trap_pc_i  in  32  PC of faulting instruction
trap_val_i  in  32  mbadaddr value
mret_i  in  1  MRET retiring this cycle
meip_i  in  1  external interrupt line, level
msip_i  in  1  software interrupt line, level
trap_vector_o  out  32  {mtvec[31:2],2'b0}
mepc_o  out  32  {mepc[31:2],2'b0}, MRET target
irq_pending_o  out  1  enabled interrupt pending

Behaviour:
- Reset (rst_i=1 at clock edge), all registered values:
  - cycles=0, instret=0, timecmp=64'hFFFF_FFFF_FFFF_FFFF
  - mtvec=RESET_MTVEC
  - mstatus.mie=0, mstatus.mpie=0
  - mie={meie,mtie,msie}=0
  - mscratch, mepc, mcause, mbadaddr, dscratch all 0
- Outputs after reset: trap_vector_o=RESET_MTVEC, mepc_o=0, irq_pending_o=0.
- Reset mid-operation overrides every write, trap and increment that cycle.
- Read path:
  - Pure combinational decode of csr_rd_addr_i; no bypass of a same-cycle write, so the old value is returned. Forwarding is the pipeline's responsibility.
  - Field packing:
    - MSTATUS={19'b0,2'b11,3'b0,mpie,3'b0,mie,3'b0}
    - MIP/MIE use bits 11/7/3
    - MCAUSE={mcause[31],27'b0,mcause[3:0]}
  - Unimplemented address: data=0, csr_illegal_o=1.
- Write path:
  - Write value: new = src (W), old|src (S), old&~src (C); old is the current register value.
  - Update visible on the cycle after the commit edge.
  - Only writable fields are stored; reserved bits read as constants.
  - Writes to read-only addresses (CYCLE/TIME/INSTRET and *H, MVENDORID, MARCHID, MIMPID, MHARTID, MISA) are ignored; no state change.
- Counters:
  - cycles += 1 every cycle.
  - instret += instr_retire_i; 64-bit wrap from all-ones to 0.
  - A CSR write to the low or high half in the same cycle replaces that half with the written value; the increment is discarded for that cycle and the other half holds.
  - TIME aliases cycles.
- Interrupts:
  - mip.mtip = (cycles >= timecmp), unsigned 64-bit.
  - mip.meip = meip_i; mip.msip = msip_i. MIP is not writable.
  - irq_pending_o = mstatus.mie & |(mip & mie), combinational from registers and input lines.
- Priority in one cycle: trap_i > mret_i > csr_wr_en_i. A lower-priority mstatus/mepc/mcause write is dropped when a higher event touches the same register.
- Trap entry, next cycle:
  - mepc=trap_pc_i, mcause={1'b0,27'b0,trap_cause_i}, mbadaddr=trap_val_i
  - mpie=mie, mie=0
- MRET: mie=mpie, mpie=1.

Optional Feature:
KAMUS_MACHINE_MODE_EN
- Defined: all machine CSRs above, trap/MRET handling and interrupts exist.
- Undefined:
  - Only CYCLE/CYCLEH/TIME/TIMEH/INSTRET/INSTRETH are implemented; all other reads return 0 with csr_illegal_o=1.
  - Trap/mret/irq inputs are ignored.
  - trap_vector_o=RESET_MTVEC, mepc_o=0, irq_pending_o=0.

Decomposition:
- kamus_pkg: csr_e (12-bit address enum), csr_op_e, mcause code constants, mstatus/mip/mie field-index localparams.
- One sub-module, kamus_csr_counter64: 64-bit counter with increment enable and independent low/high write ports. Instantiated for cycles and instret.

Test Plan:
- Reset then read MTVEC, MSTATUS -> 32'h0000_0100, 32'h0000_1800; irq_pending_o=0.
- CSR_W MSCRATCH 32'hDEAD_BEEF, then CSR_S 32'h0000_0010, then CSR_C 32'h0000_000F -> reads 32'hDEAD_BEEF, 32'hDEAD_BEFF, 32'hDEAD_BEF0 on each following cycle.
- trap_i with cause 4'd2, pc 32'h0000_0404 while mie=1 -> next cycle mepc_o=32'h0000_0404, MCAUSE=2, MSTATUS mie=0 mpie=1. Then mret_i -> mie=1, mpie=1.
- timecmp={32'h0,32'd20}, mie.mtie=1, mstatus.mie=1 after reset -> irq_pending_o rises on the cycle cycles reaches 20.
- Same-cycle CSR_W to MCYCLE value 5 -> next read of CYCLE returns 5, then 6 a cycle later. CSR_W to CYCLE is ignored; the counter keeps incrementing.
- Compile without KAMUS_MACHINE_MODE_EN -> MSTATUS reads 0 with csr_illegal_o=1; trap_i has no effect; trap_vector_o=RESET_MTVEC.
